// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
`timescale 1ns/1ps
package mul_sched_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// Request/response channels between client logic and the multiplier scheduler.
`timescale 1ns/1ps
interface mul_sched_if
    import mul_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = id_w(NREQ)
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [2*WIDTH-1:0]    resp_o;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_o, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_o, resp_err
    );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// Rotating-priority arbiter: first asserted request at or above the pointer, wrapping.
`timescale 1ns/1ps
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  w_sum;
    logic [IDW-1:0] w_idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_sum = {1'b0, i_ptr} + SW'(off);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Shares one external sequential multiplier between NREQ requesters with a done watchdog.
`timescale 1ns/1ps
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_sched_if.slave         bus,
    output logic               mul_in_valid,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_o,
    input  logic               mul_out_valid
);

    localparam int IDW = id_w(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t r_state, w_next_state;

    logic [IDW-1:0]     r_ptr, r_id;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WDW-1:0]     r_wd;
    logic [2*WIDTH-1:0] r_resp_o;
    logic               r_resp_err, r_resp_valid, r_mul_in_valid;

    logic [NREQ-1:0]  w_grant, w_req_ready;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_any, w_zero, w_wd_expire;
    logic [WIDTH-1:0] w_sel_a, w_sel_b;
    logic             w_grant_fire, w_done_fire, w_tmo_fire, w_resp_fire;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_sel_a = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_zero      = (w_sel_a == '0) || (w_sel_b == '0);
    assign w_wd_expire = (r_wd == WDW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_next_state = w_zero ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (mul_out_valid || w_wd_expire) w_next_state = ST_RESP;
            ST_RESP:  if (bus.resp_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // A done pulse in the watchdog's last cycle still wins over the timeout.
    always_comb begin
        w_req_ready  = '0;
        w_grant_fire = 1'b0;
        w_done_fire  = 1'b0;
        w_tmo_fire   = 1'b0;
        w_resp_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready  = w_grant;
                w_grant_fire = w_any;
            end
            ST_WAIT: begin
                w_done_fire = mul_out_valid;
                w_tmo_fire  = !mul_out_valid && w_wd_expire;
            end
            ST_RESP: w_resp_fire = bus.resp_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= '0;
            r_id           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_wd           <= '0;
            r_resp_o       <= '0;
            r_resp_err     <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_mul_in_valid <= 1'b0;
        end else begin
            r_mul_in_valid <= (w_next_state == ST_ISSUE);
            r_resp_valid   <= (w_next_state == ST_RESP);
            if (w_grant_fire) begin
                r_id       <= w_gnt_id;
                r_a        <= w_sel_a;
                r_b        <= w_sel_b;
                r_resp_o   <= '0;
                r_resp_err <= 1'b0;
            end
            if (w_done_fire) r_resp_o <= mul_o;
            if (w_tmo_fire) r_resp_err <= 1'b1;
            if (r_state == ST_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_resp_fire) begin
                r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_id;
    assign bus.resp_o     = r_resp_o;
    assign bus.resp_err   = r_resp_err;
    assign mul_in_valid   = r_mul_in_valid;
    assign mul_a          = r_a;
    assign mul_b          = r_b;

endmodule
